// File: rtl/multi_channel_fader.sv
// multi_channel_fader
//   N-channel brightness fader with integrated PWM. Each channel keeps a
//   duty register (0..FULL, FULL = 2**DUTY_RES) that steps once per fade
//   tick in ramp-down, ramp-up, triangle or hold mode. Channels start
//   phase-offset (FULL - k*(FULL/N_CH)) so three channels sweep a rainbow.
//   Single clock domain; the fade tick and PWM prescale are enables only.
//
// Ports
//   clk      clock
//   rst      asynchronous active-high reset
//   en       fade enable; low freezes tick counter and duties (PWM runs)
//   restart  synchronous reload of the reset duty/dir values
//   mode     0 ramp-down, 1 ramp-up, 2 triangle, 3 hold
//   step     duty change per tick
//   led      registered PWM outputs, one per channel
//   wrap     one-cycle per-channel wrap/turn pulse
//   duty     flattened duty registers, channel k at [k*(DUTY_RES+1) +: DUTY_RES+1]
module multi_channel_fader #(
   parameter int unsigned N_CH     = 3,
   parameter int unsigned DUTY_RES = 8,
   parameter int unsigned TICK_MAX = 2500000,
   parameter int unsigned PWM_DVSR = 4883
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           restart,
   input  logic [1:0]                     mode,
   input  logic [DUTY_RES-1:0]            step,
   output logic [N_CH-1:0]                led,
   output logic [N_CH-1:0]                wrap,
   output logic [N_CH*(DUTY_RES+1)-1:0]   duty
);

   localparam int unsigned DW   = DUTY_RES + 1;
   localparam int unsigned FULL = 2 ** DUTY_RES;
   localparam int unsigned TW   = $clog2(TICK_MAX);
   localparam int unsigned PW   = (PWM_DVSR > 1) ? $clog2(PWM_DVSR) : 1;
   localparam logic [DW-1:0] FULL_D = DW'(FULL);

   typedef enum logic [1:0] {
      RAMP_DOWN = 2'd0,
      RAMP_UP   = 2'd1,
      TRIANGLE  = 2'd2,
      HOLD      = 2'd3
   } mode_t;

   function automatic logic [DW-1:0] init_duty(input int unsigned k);
      return DW'(FULL - k * (FULL / N_CH));
   endfunction

   mode_t               mode_s;
   logic [TW-1:0]       tick_cnt;
   logic                tick;
   logic [PW-1:0]       pre;
   logic                pre_wrap;
   logic [DUTY_RES-1:0] pwm_cnt;
   logic [DW-1:0]       step_d;
   logic [DW-1:0]       d      [N_CH];
   logic [DW-1:0]       d_next [N_CH];
   logic [N_CH-1:0]     dir;
   logic [N_CH-1:0]     dir_next;
   logic [N_CH-1:0]     wrap_next;

   assign mode_s   = mode_t'(mode);
   assign step_d   = {1'b0, step};
   assign tick     = en && (tick_cnt == TW'(TICK_MAX - 1));
   assign pre_wrap = (pre == PW'(PWM_DVSR - 1));

   // PWM time base: cleared only by rst so restart does not glitch the PWM phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre     <= '0;
         pwm_cnt <= '0;
      end else if (pre_wrap) begin
         pre     <= '0;
         pwm_cnt <= pwm_cnt + DUTY_RES'(1);
      end else begin
         pre     <= pre + PW'(1);
      end
   end

   // Per-channel step rules. With step = 0 the duty never moves, but the
   // ramp endpoints still report a wrap.
   always_comb begin
      for (int unsigned k = 0; k < N_CH; k++) begin
         d_next[k]    = d[k];
         dir_next[k]  = dir[k];
         wrap_next[k] = 1'b0;
         if (tick) begin
            case (mode_s)
               RAMP_DOWN: begin
                  if (d[k] == '0) begin
                     wrap_next[k] = 1'b1;
                     if (step_d != '0) d_next[k] = FULL_D;
                  end else if (d[k] < step_d) begin
                     d_next[k] = '0;
                  end else begin
                     d_next[k] = d[k] - step_d;
                  end
               end
               RAMP_UP: begin
                  if (d[k] == FULL_D) begin
                     wrap_next[k] = 1'b1;
                     if (step_d != '0) d_next[k] = '0;
                  end else if ((FULL_D - d[k]) < step_d) begin
                     d_next[k] = FULL_D;
                  end else begin
                     d_next[k] = d[k] + step_d;
                  end
               end
               TRIANGLE: begin
                  if (step_d != '0) begin
                     if (!dir[k]) begin
                        if (d[k] <= step_d) begin
                           d_next[k]    = '0;
                           dir_next[k]  = 1'b1;
                           wrap_next[k] = 1'b1;
                        end else begin
                           d_next[k] = d[k] - step_d;
                        end
                     end else begin
                        if ((FULL_D - d[k]) <= step_d) begin
                           d_next[k]   = FULL_D;
                           dir_next[k] = 1'b0;
                        end else begin
                           d_next[k] = d[k] + step_d;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         dir      <= '0;
         wrap     <= '0;
         led      <= '0;
         for (int unsigned k = 0; k < N_CH; k++) d[k] <= init_duty(k);
      end else if (restart) begin
         tick_cnt <= '0;
         dir      <= '0;
         wrap     <= '0;
         led      <= '0;
         for (int unsigned k = 0; k < N_CH; k++) d[k] <= init_duty(k);
      end else begin
         if (en) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         dir  <= dir_next;
         wrap <= wrap_next;
         for (int unsigned k = 0; k < N_CH; k++) begin
            d[k]   <= d_next[k];
            led[k] <= (d[k] > {1'b0, pwm_cnt});
         end
      end
   end

   always_comb begin
      duty = '0;
      for (int unsigned k = 0; k < N_CH; k++) duty[k*DW +: DW] = d[k];
   end

endmodule

// File: tb/tb_multi_channel_fader.sv
// tb_multi_channel_fader
//   Bench for multi_channel_fader with N_CH=3, DUTY_RES=3 (FULL=8),
//   TICK_MAX=4, PWM_DVSR=1. A table of per-tick expectations, a few
//   hand-written corner sequences and a randomized run against an
//   integer reference model.
module tb_multi_channel_fader;

   localparam int FULL = 8;
   localparam int TM   = 4;

   logic       clk = 1'b0;
   logic       rst, en, restart;
   logic [1:0] mode;
   logic [2:0] step;
   logic [2:0] led, wrap;
   logic [11:0] duty;

   int errors = 0;
   int checks = 0;

   multi_channel_fader #(
      .N_CH(3), .DUTY_RES(3), .TICK_MAX(TM), .PWM_DVSR(1)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .restart(restart), .mode(mode),
      .step(step), .led(led), .wrap(wrap), .duty(duty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dv(input int k);
      return 32'(duty[k*4 +: 4]);
   endfunction

   task automatic check_duty(input string name, input int d0, input int d1, input int d2);
      check({name, " d0"}, dv(0), d0);
      check({name, " d1"}, dv(1), d1);
      check({name, " d2"}, dv(2), d2);
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
   endtask

   task automatic wait_tick();
      repeat (TM) @(posedge clk);
      #1;
   endtask

   // Count led highs per channel over one full PWM period (8 cycles).
   task automatic pwm_count(input string name, input int e0, input int e1, input int e2);
      int c [3];
      c = '{0, 0, 0};
      repeat (2) @(posedge clk);
      for (int i = 0; i < FULL; i++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 3; k++) c[k] += int'(led[k]);
      end
      check({name, " led0 highs"}, c[0], e0);
      check({name, " led1 highs"}, c[1], e1);
      check({name, " led2 highs"}, c[2], e2);
   endtask

   typedef struct {
      bit         rs;
      logic [1:0] mode;
      logic [2:0] step;
      int         d0, d1, d2;
      logic [2:0] w;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rs, input logic [1:0] m, input logic [2:0] s,
                      input int d0, input int d1, input int d2, input logic [2:0] w);
      vec_t v;
      v.rs = rs; v.mode = m; v.step = s; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.w = w;
      tbl.push_back(v);
   endtask

   // Reference model state
   int md [3];
   bit mdir [3];
   logic [2:0] mw, mled;
   int mtc, mpwm;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         md[k] = FULL - k * (FULL / 3);
         mdir[k] = 1'b0;
      end
      mw = '0; mled = '0; mtc = 0;
   endtask

   task automatic model_step();
      bit t;
      int s;
      s = int'(step);
      if (restart) begin
         model_reset();
      end else begin
         t = en && (mtc == TM - 1);
         if (en) mtc = (mtc + 1) % TM;
         for (int k = 0; k < 3; k++) begin
            mled[k] = (md[k] > mpwm);
            mw[k] = 1'b0;
            if (t) begin
               case (int'(mode))
                  0: if (md[k] == 0) begin
                        mw[k] = 1'b1;
                        if (s > 0) md[k] = FULL;
                     end else md[k] = (md[k] - s < 0) ? 0 : md[k] - s;
                  1: if (md[k] == FULL) begin
                        mw[k] = 1'b1;
                        if (s > 0) md[k] = 0;
                     end else md[k] = (md[k] + s > FULL) ? FULL : md[k] + s;
                  2: if (s > 0) begin
                        if (!mdir[k]) begin
                           if (md[k] <= s) begin md[k] = 0; mdir[k] = 1'b1; mw[k] = 1'b1; end
                           else md[k] -= s;
                        end else begin
                           if (FULL - md[k] <= s) begin md[k] = FULL; mdir[k] = 1'b0; end
                           else md[k] += s;
                        end
                     end
                  default: ;
               endcase
            end
         end
      end
      mpwm = (mpwm + 1) % FULL;
   endtask

   initial begin
      int lim;
      rst = 1'b1; en = 1'b0; restart = 1'b0; mode = 2'd3; step = 3'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_duty("reset", 8, 6, 4);
      check("reset led", 32'(led), 0);
      check("reset wrap", 32'(wrap), 0);

      // First tick lands TICK_MAX cycles after release
      @(negedge clk);
      rst = 1'b0; en = 1'b1; mode = 2'd0; step = 3'd1;
      for (int i = 0; i < TM - 1; i++) begin
         @(posedge clk);
         #1;
         check_duty("pre-tick", 8, 6, 4);
         check("pre-tick wrap", 32'(wrap), 0);
      end
      @(posedge clk);
      #1;
      check_duty("first tick", 7, 5, 3);

      // Table-driven per-tick expectations
      add(1, 0, 3, 5, 3, 1, 3'b000);
      add(0, 0, 3, 2, 0, 0, 3'b000);
      add(0, 0, 3, 0, 8, 8, 3'b110);
      add(0, 0, 3, 8, 5, 5, 3'b001);
      add(1, 1, 3, 0, 8, 7, 3'b001);
      add(0, 1, 3, 3, 0, 8, 3'b010);
      add(0, 1, 3, 6, 3, 0, 3'b100);
      add(1, 2, 3, 5, 3, 1, 3'b000);
      add(0, 2, 3, 2, 0, 0, 3'b110);
      add(0, 2, 3, 0, 3, 3, 3'b001);
      add(0, 3, 3, 0, 3, 3, 3'b000);
      add(0, 2, 3, 3, 6, 6, 3'b000);
      add(0, 2, 3, 6, 8, 8, 3'b000);
      add(0, 2, 3, 8, 5, 5, 3'b000);
      add(0, 2, 3, 5, 2, 2, 3'b000);
      foreach (tbl[i]) begin
         if (tbl[i].rs) do_restart();
         mode = tbl[i].mode;
         step = tbl[i].step;
         wait_tick();
         check_duty($sformatf("vec%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].d2);
         check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(tbl[i].w));
      end

      // Ramp-down step=1: full 9-tick period on ch0
      do_restart();
      mode = 2'd0; step = 3'd1;
      for (int i = 1; i <= 9; i++) begin
         wait_tick();
         check($sformatf("rd1 t%0d d0", i), dv(0), (i == 9) ? 8 : 8 - i);
         check($sformatf("rd1 t%0d wrap0", i), 32'(wrap[0]), (i == 9) ? 1 : 0);
      end
      @(posedge clk);
      #1;
      check("rd1 wrap0 one cycle", 32'(wrap[0]), 0);

      // restart coincident with tick
      do_restart();
      mode = 2'd0; step = 3'd1;
      repeat (TM - 1) @(posedge clk);
      #1 restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
      check_duty("restart@tick", 8, 6, 4);
      check("restart@tick wrap", 32'(wrap), 0);
      repeat (TM - 1) @(posedge clk);
      #1;
      check_duty("restart cnt", 8, 6, 4);
      @(posedge clk);
      #1;
      check_duty("restart first tick", 7, 5, 3);

      // en low for 10 cycles mid-ramp
      begin
         bit hi, lo;
         do_restart();
         mode = 2'd0; step = 3'd1;
         wait_tick();
         wait_tick();
         repeat (2) @(posedge clk);
         #1 en = 1'b0;
         hi = 0; lo = 0;
         repeat (10) begin
            @(posedge clk);
            #1;
            if (led[0]) hi = 1; else lo = 1;
         end
         check_duty("en freeze", 6, 4, 2);
         check("en freeze pwm toggles", {30'd0, hi, lo}, 3);
         en = 1'b1;
         @(posedge clk);
         #1;
         check("en resume hold", dv(0), 6);
         @(posedge clk);
         #1;
         check("en resume tick", dv(0), 5);
      end

      // PWM duty ratios
      do_restart();
      en = 1'b0;
      pwm_count("pwm full", 8, 6, 4);
      en = 1'b1;
      do_restart();
      mode = 2'd0; step = 3'd5;
      wait_tick();
      check_duty("pwm setup", 3, 1, 0);
      en = 1'b0;
      pwm_count("pwm partial", 3, 1, 0);

      // Async reset while led0 is high
      en = 1'b1;
      do_restart();
      mode = 2'd0; step = 3'd1;
      wait_tick();
      en = 1'b0;
      lim = 0;
      @(negedge clk);
      while (!led[0] && lim < 16) begin
         @(negedge clk);
         lim++;
      end
      check("async rst led0 high before", 32'(led[0]), 1);
      #2 rst = 1'b1;
      #1;
      check("async rst led", 32'(led), 0);
      check_duty("async rst", 8, 6, 4);

      // Randomized run against the reference model
      repeat (2) @(posedge clk);
      model_reset();
      mpwm = 0;
      mode = 2'd0; step = 3'd1;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 800; n++) begin
         en = ($urandom_range(0, 7) != 0);
         restart = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) step = 3'($urandom_range(1, 7));
         model_step();
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d duty", n), 32'(duty),
               32'({4'(md[2]), 4'(md[1]), 4'(md[0])}));
         check($sformatf("rnd%0d wrap", n), 32'(wrap), 32'(mw));
         check($sformatf("rnd%0d led", n), 32'(led), 32'(mled));
         @(negedge clk);
      end
      restart = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_channel_fader.md
# multi_channel_fader

Parametrised N-channel brightness fader with integrated PWM, generalising the single-channel ramp-down fader used in the Rainbow PWM design. Each channel owns a duty register that steps once per fade tick in one of four modes: ramp-down, ramp-up, triangle (breathe) or hold. Channels start phase-offset so that three channels produce a rainbow sweep. Everything is single-clock synchronous: no logic is clocked by a derived pulse.

## Interface
- N_CH, 3, number of channels (≥1)
- DUTY_RES, 8, PWM resolution R; full scale FULL = 2^R
- TICK_MAX, 2500000, clk cycles per fade tick (≥2)
- PWM_DVSR, 4883, clk cycles per PWM counter increment (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  fade enable; 0 freezes tick counter and duties (PWM keeps running)
- restart  in  1  synchronous reload of reset duty/dir values
- mode  in  2  0 ramp-down, 1 ramp-up, 2 triangle, 3 hold
- step  in  R  duty change per tick; 0 = no change
- led  out  N_CH  registered PWM outputs
- wrap  out  N_CH  one-cycle per-channel wrap/turn pulse
- duty  out  N_CH*(R+1)  flattened duty registers, channel k at [k*(R+1)+:R+1]

## Operation
- Reset / restart values: d_k = FULL − k*(FULL/N_CH) (integer division), dir_k = 0 (down), wrap = 0, led = 0, tick_cnt = 0. PWM prescaler and PWM counter are cleared by rst only.
- Tick: tick_cnt counts 0..TICK_MAX−1 while en=1. tick is asserted for the one cycle in which tick_cnt = TICK_MAX−1 and en = 1; tick_cnt wraps to 0 in that cycle. When en = 0, tick_cnt holds.
- Duty is R+1 bits wide with range 0..FULL. All comparisons are unsigned; d never leaves that range.
- On tick, each channel updates according to mode (sampled in the tick cycle):
  - Ramp-down: if d = 0, d ← FULL and wrap_k pulses; else if d < step, d ← 0; else d ← d − step.
  - Ramp-up: if d = FULL, d ← 0 and wrap_k pulses; else if FULL − d < step, d ← FULL; else d ← d + step.
  - Triangle, dir = 0: if d ≤ step, d ← 0, dir ← 1, wrap_k pulses; else d ← d − step.
  - Triangle, dir = 1: if FULL − d ≤ step, d ← FULL, dir ← 0; else d ← d + step.
  - Hold: no change.
  - step = 0: no duty change in any mode. The wrap pulse still fires in ramp modes at the endpoint.
- dir is only modified in triangle mode and is retained across mode changes.
- restart has priority over tick in the same cycle.
- PWM: the prescaler counts 0..PWM_DVSR−1. On wrap of the prescaler, pwm_cnt (R bits) increments modulo FULL. Next-cycle led_k = (d_k > pwm_cnt), so d = 0 gives always off and d = FULL gives always on.

## Timing
- Duty, dir and wrap update on the clk edge ending the tick cycle and are visible the next cycle. wrap is high for exactly 1 cycle.
- led reflects a new duty 1 cycle after the duty update.
- rst asserted mid-operation immediately forces all outputs to their reset values. On deassertion, the first tick occurs TICK_MAX cycles after the first enabled cycle.
- restart: duty equals the reset value the cycle after restart. tick_cnt restarts from 0.
- en falling in the tick cycle: that tick is suppressed.

## Test plan
Parameters for all tests: N_CH=3, DUTY_RES=3 (FULL=8), TICK_MAX=4, PWM_DVSR=1.
- Reset: duty = 8,6,4; led = 000; wrap = 000 while rst is high and after release, until the first tick.
- Ramp-down, step=1: ch0 goes 8,7,…,1,0,8. wrap0 pulses once, on the 0→8 update (9 ticks = 36 cycles per period).
- Ramp-down, step=3: ch0 goes 8,5,2,0,8 with wrap0 on the 0→8 update. Ramp-up, step=3, from ch2=4: 7,8,0 with wrap2 on the 8→0 update.
- Triangle, step=3: ch0 goes 8,5,2,0 (wrap0 pulses, dir=1),3,6,8 (dir=0),5. Switching to hold mid-way freezes duty; returning to triangle resumes in the retained direction.
- en=0 for 10 cycles mid-ramp: duty and tick_cnt freeze and PWM keeps toggling. restart pulsed together with tick: duty = 8,6,4 and no step is applied.
- PWM: duty 3 → led high for 3 of every 8 cycles; duty 0 → never high; duty 8 → constantly high. Async rst mid-high forces led = 0 in the same cycle.
